// File: rtl/spart_pkg.sv
// Shared types and defaults for the SPART receive sampler.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } rx_state_t;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_DATA_BITS  = 8;

  localparam int RX_TICK_W = $clog2(SPART_OVERSAMPLE);
  localparam int RX_BIT_W  = $clog2(SPART_DATA_BITS) + 1;

  // 2-of-3 majority, used by the optional sample vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_rx_sampler_sync2.sv
// Two-flop synchronizer for the asynchronous RXD line; resets to the idle level (1).
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw line through two flops; reset to line-idle so no false start follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/spart_rx_sampler.sv
// SPART receive front-end: start detect, mid-bit sampling, stop check.
// Emits one bit_out/bit_valid strobe per data bit (LSB first) to the shifter.
// Optional build macro SPART_RX_MAJORITY_VOTE_EN: start-verify, data and stop
// decisions use a 2-of-3 vote of rxd_s at tick_cnt D-2, D-1, D.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a low sample on a tick
// START    | half-bit wait, then verify the start bit is still low
// DATA     | sample each data bit at mid-bit, strobe it out
// STOP     | sample the stop bit, flag frame_done / frame_err
// BRK_WAIT | stop bit was low; wait for line high before re-arming
module spart_rx_sampler
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE,
  parameter int DATA_BITS  = SPART_DATA_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic brg_tick,
  input  logic rxd,
  output logic bit_out,
  output logic bit_valid,
  output logic frame_done,
  output logic frame_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_DEC   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [TW-1:0] r_tick_cnt;
  logic [TW-1:0] w_tick_cnt_nxt;
  logic [BW-1:0] r_bit_cnt;
  logic [BW-1:0] w_bit_cnt_nxt;

  logic r_bit_out;
  logic r_bit_valid;
  logic r_frame_done;
  logic r_frame_err;
  logic w_bit_out_nxt;
  logic w_bit_valid_nxt;
  logic w_frame_done_nxt;
  logic w_frame_err_nxt;

  logic w_rxd_s;
  logic w_sample;

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (w_rxd_s)
  );

`ifdef SPART_RX_MAJORITY_VOTE_EN
  logic          r_vote0;
  logic          r_vote1;
  logic [TW-1:0] w_dec_cnt;

  // START decides at half-bit, DATA/STOP at full bit; the vote window tracks that.
  assign w_dec_cnt = (r_state == START) ? START_DEC : BIT_DEC;

  // Capture the two samples preceding the decision tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vote0 <= 1'b1;
      r_vote1 <= 1'b1;
    end else if (brg_tick) begin
      if (r_tick_cnt == w_dec_cnt - TW'(2)) r_vote0 <= w_rxd_s;
      if (r_tick_cnt == w_dec_cnt - TW'(1)) r_vote1 <= w_rxd_s;
    end
  end

  assign w_sample = maj3(r_vote0, r_vote1, w_rxd_s);
`else
  assign w_sample = w_rxd_s;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, counter and strobe decode; everything advances only on brg_tick.
  always_comb begin
    w_state_nxt      = r_state;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_bit_out_nxt    = r_bit_out;
    w_bit_valid_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_frame_err_nxt  = r_frame_err;

    if (brg_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rxd_s) begin
            w_state_nxt    = START;
            w_tick_cnt_nxt = '0;
          end
        end

        START: begin
          if (r_tick_cnt == START_DEC) begin
            if (!w_sample) begin
              w_state_nxt     = DATA;
              w_tick_cnt_nxt  = '0;
              w_bit_cnt_nxt   = '0;
              w_frame_err_nxt = 1'b0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end

        DATA: begin
          if (r_tick_cnt == BIT_DEC) begin
            w_bit_out_nxt   = w_sample;
            w_bit_valid_nxt = 1'b1;
            w_tick_cnt_nxt  = '0;
            w_bit_cnt_nxt   = r_bit_cnt + BW'(1);
            if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end

        STOP: begin
          if (r_tick_cnt == BIT_DEC) begin
            w_frame_done_nxt = 1'b1;
            w_tick_cnt_nxt   = '0;
            if (w_sample) begin
              w_state_nxt = IDLE;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = BRK_WAIT;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end

        BRK_WAIT: begin
          // Only a high line re-arms; a held-low break never looks like a new start.
          if (w_rxd_s) w_state_nxt = IDLE;
        end

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Counters and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_bit_out    <= w_bit_out_nxt;
      r_bit_valid  <= w_bit_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/spart_rx_sampler.md
Name: spart_rx_sampler

Overview:
Receive front-end of the SPART, directly upstream of the 8-bit receive shifter.
- Takes the raw asynchronous RXD line and a 16x baud-rate enable tick.
- Detects the start bit, samples each data bit at mid-bit, and emits one serial bit plus a one-cycle strobe per data bit (feeds the shifter's nxt_bit/en).
- Checks the stop bit and reports frame completion or framing error.

Parameters:
- OVERSAMPLE, 16, brg_tick pulses per bit period; even, >=8.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- brg_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- rxd  input  1  asynchronous serial line; idle high.
- bit_out  output  1  sampled data bit; valid when bit_valid=1.
- bit_valid  output  1  one-clk strobe per data bit.
- frame_done  output  1  one-clk strobe at the stop-bit sample.
- frame_err  output  1  stop bit sampled low; held until the next start bit is accepted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset values:
  - sync flops = 1.
  - state = IDLE; tick counter = 0; bit counter = 0.
  - bit_out = 0, bit_valid = 0, frame_done = 0, frame_err = 0, busy = 0.
- rxd passes through a 2-flop synchronizer; all logic uses rxd_s.
- tick_cnt (log2 OVERSAMPLE bits) and bit_cnt (log2(DATA_BITS)+1 bits) advance only on brg_tick.
- State machine:
  - IDLE: on brg_tick with rxd_s=0 -> START, tick_cnt=0.
  - START: on tick, tick_cnt++. At tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rxd_s=0 -> DATA, tick_cnt=0, bit_cnt=0, frame_err cleared.
    - rxd_s=1 -> false start, back to IDLE with no strobes.
  - DATA: on tick, tick_cnt++. At tick_cnt==OVERSAMPLE-1:
    - bit_out<=sample, bit_valid<=1 for the next clk only.
    - tick_cnt=0, bit_cnt++.
    - After the DATA_BITS-th bit -> STOP.
  - STOP: at tick_cnt==OVERSAMPLE-1, frame_done<=1 for one clk.
    - rxd_s=1 -> IDLE.
    - rxd_s=0 -> frame_err<=1, go to BRK_WAIT.
  - BRK_WAIT: stay until rxd_s=1 on a tick, then IDLE. No new start is detected while the line is held low (break).
- Latency:
  - Strobes are registered: asserted the clk after the deciding brg_tick.
  - rxd to first logic is 2 clk synchronizer delay.
- Boundary conditions:
  - brg_tick absent: FSM holds; strobes stay 0.
  - brg_tick on consecutive clks is legal.
  - rst mid-frame: immediate return to reset values; a partial frame produces no further strobes.
  - Back-to-back frames: a start bit immediately after the stop sample is detected on the first IDLE tick.
- Exactly DATA_BITS bit_valid pulses per accepted frame. bit_valid and frame_done are never high in the same clk.

Optional Feature:
- Macro: SPART_RX_MAJORITY_VOTE_EN.
- Defined: each data, start-verify and stop sample is the 2-of-3 majority of rxd_s captured at tick_cnt = D-2, D-1 and D, where D is the decision count.
  - Decision points and strobe timing are unchanged.
  - The first-edge detect in IDLE is not voted.
- Undefined: single sample at the decision tick. Vote registers are absent.

Decomposition:
- Shared package spart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BRK_WAIT}.
  - OVERSAMPLE and DATA_BITS defaults.
  - Counter-width constants derived with $clog2.
- One sub-module: spart_sync2, a 2-flop synchronizer with reset value 1. The top FSM and counters stay in a single module.

Test Plan (OVERSAMPLE=16, DATA_BITS=8, brg_tick every 4 clks unless noted):
1. Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1) -> 8 bit_valid pulses 64 clks apart carrying 1,0,1,0,0,1,0,1; one frame_done; frame_err=0; busy low after stop.
2. 8-tick low glitch on idle rxd -> START entered, returns to IDLE; no bit_valid, no frame_done.
3. Frame 0x3C with stop bit 0 and the line held low 40 ticks -> frame_done=1, frame_err=1, FSM stays in BRK_WAIT until rxd=1; next valid frame clears frame_err at its start verify.
4. rst asserted after bit 3 of 0xFF -> all outputs 0 next clk; a following 0x55 frame decodes cleanly with exactly 8 strobes.
5. Back-to-back 0x00 then 0xFF with no idle gap, brg_tick every clk -> 16 bit_valid total, 2 frame_done, no err.
6. With SPART_RX_MAJORITY_VOTE_EN: 1-tick low spike at tick 14 of a '1' bit in 0xFF -> bit_out remains 1. Without the macro, the same spike at tick 15 -> bit_out=0.
